// File: rtl/baseline_calib_ctrl.sv
// baseline_calib_ctrl: measures the H-gain ADC baseline (or takes a host value)
// and hands it to the baseline-subtracting DSP stage with a one-cycle strobe.
module baseline_calib_ctrl #(
  parameter int SAMPLE_NUM_PER_CLK   = 8,
  parameter int SAMPLE_WIDTH         = 16,
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int TIMEOUT_CYCLES       = 1024
) (
  input  logic                                         ACLK,
  input  logic                                         ARESET,
  input  logic                                         START,
  input  logic                                         MANUAL_EN,
  input  logic signed [12:0]                           MANUAL_BASELINE,
  input  logic [3:0]                                   ACCUM_LOG2,
  input  logic [SAMPLE_NUM_PER_CLK*SAMPLE_WIDTH-1:0]   H_S_AXIS_TDATA,
  input  logic                                         H_S_AXIS_TVALID,
  output logic                                         SET_CONFIG,
  output logic signed [12:0]                           H_GAIN_BASELINE,
  output logic                                         BUSY,
  output logic                                         DONE,
  output logic                                         ERROR
);
  localparam int LANE_SH = $clog2(SAMPLE_NUM_PER_CLK);
  localparam int OFF     = SAMPLE_WIDTH - ADC_RESOLUTION_WIDTH;
  localparam int IW      = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, ACCUM, CALC, APPLY, SETTLE, FIN} state_t;
  state_t             state;
  logic [3:0]         k;
  logic [3:0]         k_clamp;
  logic signed [26:0] acc;
  logic signed [26:0] beat_sum;
  logic [12:0]        beat_cnt;
  logic [IW-1:0]      idle_cnt;
  logic               settle_cnt;
  logic               last_beat;
  logic signed [12:0] mean;
  logic               unused_lsbs;
  // lanes are left-justified, so the low bits below the ADC code carry nothing
  assign unused_lsbs = ^H_S_AXIS_TDATA;
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < SAMPLE_NUM_PER_CLK; i++)
      beat_sum = beat_sum + 27'($signed(H_S_AXIS_TDATA[i*SAMPLE_WIDTH+OFF +: ADC_RESOLUTION_WIDTH]));
  end
  assign k_clamp   = ACCUM_LOG2 > 4'd12 ? 4'd12 : ACCUM_LOG2;
  assign last_beat = beat_cnt == (13'd1 << k) - 13'd1;
  // arithmetic shift floors toward minus infinity, dividing by beats*lanes
  assign mean      = 13'(acc >>> (32'(k) + LANE_SH));
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state           <= IDLE;
      SET_CONFIG      <= 1'b0;
      BUSY            <= 1'b0;
      DONE            <= 1'b0;
      ERROR           <= 1'b0;
      H_GAIN_BASELINE <= -13'sd1024;
      k               <= '0;
      acc             <= '0;
      beat_cnt        <= '0;
      idle_cnt        <= '0;
      settle_cnt      <= 1'b0;
    end else begin
      SET_CONFIG <= 1'b0;
      DONE       <= 1'b0;
      case (state)
        IDLE: if (START) begin
          BUSY <= 1'b1;
          if (MANUAL_EN) begin
            H_GAIN_BASELINE <= MANUAL_BASELINE;
            SET_CONFIG      <= 1'b1;
            state           <= APPLY;
          end else begin
            k        <= k_clamp;
            acc      <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
            ERROR    <= 1'b0;
            state    <= ACCUM;
          end
        end
        ACCUM: if (H_S_AXIS_TVALID) begin
          acc      <= acc + beat_sum;
          beat_cnt <= beat_cnt + 13'd1;
          idle_cnt <= '0;
          if (last_beat) state <= CALC;
        end else begin
          idle_cnt <= idle_cnt + IW'(1);
          if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
            ERROR <= 1'b1;
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end
        CALC: begin
          H_GAIN_BASELINE <= mean;
          SET_CONFIG      <= 1'b1;
          state           <= APPLY;
        end
        APPLY: begin
          settle_cnt <= 1'b0;
          state      <= SETTLE;
        end
        SETTLE: begin
          settle_cnt <= 1'b1;
          if (settle_cnt) begin
            DONE  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
